sg_write_arbiter: RTL and testbench



---
 rtl/sg_write_arbiter_pkg.sv | 36 +++
 rtl/sg_write_arbiter_if.sv | 29 ++
 rtl/sg_write_arbiter_rr_pick.sv | 62 ++++++
 rtl/sg_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_sg_write_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sg_write_arbiter_pkg.sv
// Shared types and helpers for the SRAM write-path arbiter: FSM state encoding,
// priority-vector slicing and the watchdog beat-counter width.
package sg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // Upper bounds for the generic priority slicer (64 ports x 8-bit priority).
  localparam int unsigned prio_vec_max = 512;
  localparam int unsigned prio_w_max   = 8;

  localparam int unsigned max_beats_default = 256;
  localparam int unsigned beat_cnt_width    = $clog2(max_beats_default + 1);

  function automatic int unsigned beat_cnt_w(input int unsigned mb);
    return $clog2(mb + 1);
  endfunction

  function automatic logic [prio_w_max-1:0] prio_of(
    input logic [prio_vec_max-1:0] vec,
    input int unsigned             i,
    input int unsigned             w
  );
    logic [prio_vec_max-1:0] sh_s;
    logic [prio_w_max-1:0]   one_s;
    logic [prio_w_max-1:0]   mask_s;
    one_s  = {{(prio_w_max-1){1'b0}}, 1'b1};
    sh_s   = vec >> (i * w);
    mask_s = (one_s << w) - one_s;
    return sh_s[prio_w_max-1:0] & mask_s;
  endfunction

endpackage

// File: rtl/sg_write_arbiter_if.sv
// Bundle of the arbiter's writer-facing and back-end signals; the arbiter
// attaches through the slave modport, the writer side through master.
interface sg_write_arbiter_if #(
  parameter int unsigned num_of_ports      = 16,
  parameter int unsigned sg_des_width      = 4,
  parameter int unsigned sg_priority_width = 3
) ();

  logic                                        busy;
  logic [num_of_ports-1:0]                     request;
  logic [num_of_ports*sg_priority_width-1:0]   req_priority;
  logic [num_of_ports-1:0]                     eop;
  logic [num_of_ports-1:0]                     transfering;
  logic                                        grant_valid;
  logic [sg_des_width-1:0]                     grant_port;
  logic [sg_priority_width-1:0]                grant_priority;
  logic                                        abort;

  modport master (
    output busy, request, req_priority, eop,
    input  transfering, grant_valid, grant_port, grant_priority, abort
  );

  modport slave (
    input  busy, request, req_priority, eop,
    output transfering, grant_valid, grant_port, grant_priority, abort
  );

endinterface

// File: rtl/sg_write_arbiter_rr_pick.sv
// Combinational winner search: highest priority among requesters, ties broken
// by the first requesting index at or after rr_ptr (wrapping).
module sg_rr_pick
  import sg_arb_pkg::*;
#(
  parameter int unsigned num_of_ports      = 16,
  parameter int unsigned sg_des_width      = 4,
  parameter int unsigned sg_priority_width = 3
) (
  input  logic [num_of_ports-1:0]                   request,
  input  logic [num_of_ports*sg_priority_width-1:0] req_priority,
  input  logic [sg_des_width-1:0]                   rr_ptr,
  output logic [sg_des_width-1:0]                   winner,
  output logic                                      found
);

  logic [prio_vec_max-1:0]      prio_vec_s;
  logic [sg_priority_width-1:0] max_prio_s;
  logic [sg_priority_width-1:0] cand_s;
  logic [num_of_ports-1:0]      req_sh_s;
  int unsigned                  idx_s;

  assign prio_vec_s = prio_vec_max'(req_priority);

  // Two passes: find the top requesting priority, then the rotated first match.
  always_comb begin
    max_prio_s = '0;
    cand_s     = '0;
    req_sh_s   = '0;
    idx_s      = 32'd0;
    winner     = '0;
    found      = 1'b0;

    for (int unsigned i = 0; i < num_of_ports; i++) begin
      cand_s   = sg_priority_width'(prio_of(prio_vec_s, i, sg_priority_width));
      req_sh_s = request >> i;
      if (req_sh_s[0] && (cand_s > max_prio_s)) begin
        max_prio_s = cand_s;
      end else begin
        max_prio_s = max_prio_s;
      end
    end

    for (int unsigned k = 0; k < num_of_ports; k++) begin
      idx_s = 32'(rr_ptr) + k;
      if (idx_s >= num_of_ports) begin
        idx_s = idx_s - num_of_ports;
      end else begin
        idx_s = idx_s;
      end
      cand_s   = sg_priority_width'(prio_of(prio_vec_s, idx_s, sg_priority_width));
      req_sh_s = request >> idx_s;
      if (!found && req_sh_s[0] && (cand_s == max_prio_s)) begin
        winner = sg_des_width'(idx_s);
        found  = 1'b1;
      end else begin
        found  = found;
      end
    end
  end

endmodule

// File: rtl/sg_write_arbiter.sv
// Grants the single SRAM write path to one segment writer at a time, holds it
// until eop (or watchdog/drop abort), then inserts one RELEASE gap cycle.
module sg_write_arbiter
  import sg_arb_pkg::*;
#(
  parameter int unsigned num_of_ports      = 16,
  parameter int unsigned sg_des_width      = 4,
  parameter int unsigned sg_priority_width = 3,
  parameter int unsigned max_beats         = 256
) (
  input logic               clk,
  input logic               rst,
  sg_write_arbiter_if.slave bus
);

  localparam int unsigned cnt_w = beat_cnt_w(max_beats);
  localparam logic [num_of_ports-1:0] one_hot_base = {{(num_of_ports-1){1'b0}}, 1'b1};
  localparam logic [sg_des_width-1:0] last_port    = sg_des_width'(num_of_ports - 32'd1);
  localparam logic [sg_des_width-1:0] port_one     = {{(sg_des_width-1){1'b0}}, 1'b1};
  localparam logic [cnt_w-1:0]        cnt_last     = cnt_w'(max_beats - 32'd1);
  localparam logic [cnt_w-1:0]        cnt_one      = {{(cnt_w-1){1'b0}}, 1'b1};

  arb_state_e                   state_r, state_s;
  logic [sg_des_width-1:0]      rr_ptr_r, rr_ptr_s;
  logic [cnt_w-1:0]             beat_cnt_r, beat_cnt_s;
  logic [num_of_ports-1:0]      transfering_r, transfering_s;
  logic                         grant_valid_r, grant_valid_s;
  logic [sg_des_width-1:0]      grant_port_r, grant_port_s;
  logic [sg_priority_width-1:0] grant_priority_r, grant_priority_s;
  logic                         abort_r, abort_s;

  logic [sg_des_width-1:0]      win_port_s;
  logic                         win_found_s;
  logic [sg_priority_width-1:0] win_prio_s;
  logic [prio_vec_max-1:0]      prio_vec_s;
  logic [num_of_ports-1:0]      gnt_req_vec_s;
  logic [num_of_ports-1:0]      gnt_eop_vec_s;

  sg_rr_pick #(
    .num_of_ports      (num_of_ports),
    .sg_des_width      (sg_des_width),
    .sg_priority_width (sg_priority_width)
  ) u_pick (
    .request      (bus.request),
    .req_priority (bus.req_priority),
    .rr_ptr       (rr_ptr_r),
    .winner       (win_port_s),
    .found        (win_found_s)
  );

  assign prio_vec_s    = prio_vec_max'(bus.req_priority);
  assign win_prio_s    = sg_priority_width'(prio_of(prio_vec_s, 32'(win_port_s), sg_priority_width));
  assign gnt_req_vec_s = bus.request >> grant_port_r;
  assign gnt_eop_vec_s = bus.eop >> grant_port_r;

  // Next-state and next-output decode; eop outranks both abort causes.
  always_comb begin
    state_s          = state_r;
    rr_ptr_s         = rr_ptr_r;
    beat_cnt_s       = beat_cnt_r;
    transfering_s    = transfering_r;
    grant_valid_s    = grant_valid_r;
    grant_port_s     = grant_port_r;
    grant_priority_s = grant_priority_r;
    abort_s          = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (!bus.busy && win_found_s) begin
          state_s          = ST_XFER;
          transfering_s    = one_hot_base << win_port_s;
          grant_valid_s    = 1'b1;
          grant_port_s     = win_port_s;
          grant_priority_s = win_prio_s;
          beat_cnt_s       = '0;
        end else begin
          state_s          = ST_IDLE;
        end
      end

      ST_XFER: begin
        if (gnt_eop_vec_s[0] || !gnt_req_vec_s[0] || (beat_cnt_r == cnt_last)) begin
          state_s          = ST_RELEASE;
          transfering_s    = '0;
          grant_valid_s    = 1'b0;
          grant_port_s     = '0;
          grant_priority_s = '0;
          abort_s          = !gnt_eop_vec_s[0];
          // rr_ptr only matters back in IDLE, so it can be loaded at the decision edge.
          if (grant_port_r == last_port) begin
            rr_ptr_s = '0;
          end else begin
            rr_ptr_s = grant_port_r + port_one;
          end
        end else begin
          beat_cnt_s = beat_cnt_r + cnt_one;
        end
      end

      ST_RELEASE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s          = ST_IDLE;
        transfering_s    = '0;
        grant_valid_s    = 1'b0;
        grant_port_s     = '0;
        grant_priority_s = '0;
      end
    endcase
  end

  // State, pointer, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r          <= ST_IDLE;
      rr_ptr_r         <= '0;
      beat_cnt_r       <= '0;
      transfering_r    <= '0;
      grant_valid_r    <= 1'b0;
      grant_port_r     <= '0;
      grant_priority_r <= '0;
      abort_r          <= 1'b0;
    end else begin
      state_r          <= state_s;
      rr_ptr_r         <= rr_ptr_s;
      beat_cnt_r       <= beat_cnt_s;
      transfering_r    <= transfering_s;
      grant_valid_r    <= grant_valid_s;
      grant_port_r     <= grant_port_s;
      grant_priority_r <= grant_priority_s;
      abort_r          <= abort_s;
    end
  end

  assign bus.transfering    = transfering_r;
  assign bus.grant_valid    = grant_valid_r;
  assign bus.grant_port     = grant_port_r;
  assign bus.grant_priority = grant_priority_r;
  assign bus.abort          = abort_r;

endmodule

// File: tb/tb_sg_write_arbiter.sv
// Directed bench for sg_write_arbiter: a transaction-level model predicts every
// output each cycle, and a grant log is pinned against hand-computed sequences.
module tb_sg_write_arbiter;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam int PW = 3;
  localparam int MB = 8;

  logic clk;
  logic rst;

  sg_write_arbiter_if #(.num_of_ports(N), .sg_des_width(IW), .sg_priority_width(PW)) bus ();

  sg_write_arbiter #(
    .num_of_ports      (N),
    .sg_des_width      (IW),
    .sg_priority_width (PW),
    .max_beats         (MB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model state: phase 0 = no grant, 1 = granted, 2 = gap after a grant.
  int          m_phase = 0;
  int          m_gport = 0;
  int          m_gprio = 0;
  int          m_beats = 0;
  int          m_ptr   = 0;
  logic [N-1:0] m_trans = '0;
  bit          m_gv    = 1'b0;
  bit          m_abort = 1'b0;

  // Highest priority wins; scanning from the pointer, only a strictly higher
  // priority displaces the current pick, so ties go to the earliest rotated index.
  function automatic int pick(input logic [N-1:0] req, input logic [N*PW-1:0] pr, input int ptr);
    int best;
    int bp;
    int idx;
    best = -1;
    bp   = -1;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (req[idx] && int'(pr[idx*PW +: PW]) > bp) begin
        bp   = int'(pr[idx*PW +: PW]);
        best = idx;
      end
    end
    return best;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_phase = 0; m_gport = 0; m_gprio = 0; m_beats = 0; m_ptr = 0;
      m_trans = '0; m_gv = 1'b0; m_abort = 1'b0;
    end else if (m_phase == 0) begin
      m_abort = 1'b0;
      if (!bus.busy && bus.request != '0) begin
        m_gport = pick(bus.request, bus.req_priority, m_ptr);
        m_gprio = int'(bus.req_priority[m_gport*PW +: PW]);
        m_beats = 0;
        m_phase = 1;
        m_trans = '0;
        m_trans[m_gport] = 1'b1;
        m_gv = 1'b1;
      end
    end else if (m_phase == 1) begin
      if (bus.eop[m_gport] || !bus.request[m_gport] || m_beats == MB - 1) begin
        m_abort = !bus.eop[m_gport];
        m_phase = 2;
        m_trans = '0;
        m_gv    = 1'b0;
        m_ptr   = (m_gport + 1) % N;
      end else begin
        m_beats++;
      end
    end else begin
      m_phase = 0;
      m_abort = 1'b0;
    end
  end

  int log_port[$];
  int log_len[$];
  int abort_cnt = 0;
  bit mon_prev  = 1'b0;

  // Per-cycle comparison against the model plus grant logging.
  initial forever begin
    @(posedge clk);
    #1;
    check("transfering", 32'(bus.transfering), 32'(m_trans));
    check("grant_valid", 32'(bus.grant_valid), 32'(m_gv));
    check("abort", 32'(bus.abort), 32'(m_abort));
    if (m_gv) begin
      check("grant_port", 32'(bus.grant_port), 32'(m_gport));
      check("grant_priority", 32'(bus.grant_priority), 32'(m_gprio));
    end
    if (bus.grant_valid) begin
      if (!mon_prev) begin
        log_port.push_back(int'(bus.grant_port));
        log_len.push_back(0);
      end
      log_len[log_len.size()-1] = log_len[log_len.size()-1] + 1;
    end
    mon_prev = bus.grant_valid;
    if (bus.abort) abort_cnt++;
  end

  task automatic set_prio(input int p, input logic [PW-1:0] v);
    bus.req_priority[p*PW +: PW] = v;
  endtask

  task automatic wait_grant();
    int t;
    t = 0;
    while (!bus.grant_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("grant_wait", 32'(t < 50), 32'd1);
  endtask

  // Writer for port p: eop in the len-th transfer cycle; keep=0 drops request with eop.
  task automatic serve(input int p, input int len, input bit keep);
    wait_grant();
    repeat (len - 1) @(negedge clk);
    bus.eop[p] = 1'b1;
    if (!keep) bus.request[p] = 1'b0;
    @(negedge clk);
    bus.eop[p] = 1'b0;
  endtask

  int exp_ports[12] = '{0, 5, 15, 0, 2, 9, 1, 7, 3, 3, 4, 0};
  int k;

  initial begin
    rst = 1'b0;
    bus.busy = 1'b0;
    bus.request = '0;
    bus.req_priority = '0;
    bus.eop = '0;
    repeat (3) @(negedge clk);
    check("rst_transfering", 32'(bus.transfering), 32'd0);
    check("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
    check("rst_abort", 32'(bus.abort), 32'd0);
    check("rst_grant_port", 32'(bus.grant_port), 32'd0);
    check("rst_grant_priority", 32'(bus.grant_priority), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Round-robin among equal priorities, continuous requests.
    set_prio(0, 3'd3); set_prio(5, 3'd3); set_prio(15, 3'd3);
    bus.request = 16'h8021;
    serve(0, 2, 1'b1);
    serve(5, 2, 1'b1);
    serve(15, 2, 1'b1);
    serve(0, 2, 1'b1);
    bus.request = '0;
    bus.req_priority = '0;
    repeat (2) @(negedge clk);

    // Single request, 5-beat packet.
    set_prio(2, 3'd2);
    bus.request = 16'h0004;
    @(negedge clk);
    @(negedge clk);
    check("single_trans", 32'(bus.transfering), 32'h0004);
    check("single_port", 32'(bus.grant_port), 32'd2);
    serve(2, 4, 1'b0);
    @(negedge clk);

    // Priority: port 9 (6) before port 1 (1).
    set_prio(1, 3'd1); set_prio(9, 3'd6);
    bus.request = 16'h0202;
    serve(9, 3, 1'b0);
    serve(1, 3, 1'b0);
    @(negedge clk);

    // Busy gating, then busy mid-transfer.
    set_prio(7, 3'd4);
    bus.busy = 1'b1;
    bus.request = 16'h0080;
    repeat (4) @(negedge clk);
    check("busy_block", 32'(bus.grant_valid), 32'd0);
    bus.busy = 1'b0;
    @(negedge clk);
    check("busy_release_gv", 32'(bus.grant_valid), 32'd1);
    check("busy_release_trans", 32'(bus.transfering), 32'h0080);
    bus.busy = 1'b1;
    @(negedge clk);
    check("busy_mid_xfer", 32'(bus.transfering), 32'h0080);
    bus.eop[7] = 1'b1;
    bus.request[7] = 1'b0;
    @(negedge clk);
    bus.eop = '0;
    bus.busy = 1'b0;
    @(negedge clk);

    // Watchdog: no eop, abort in the 9th cycle after the grant.
    set_prio(3, 3'd5);
    bus.request = 16'h0008;
    wait_grant();
    k = 1;
    while (!bus.abort && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("watchdog_cycle", 32'(k), 32'd9);
    check("watchdog_trans", 32'(bus.transfering), 32'd0);
    bus.request = '0;
    @(negedge clk);

    // Request dropped in the 3rd transfer cycle.
    bus.request = 16'h0008;
    wait_grant();
    repeat (2) @(negedge clk);
    bus.request = '0;
    @(negedge clk);
    check("drop_abort", 32'(bus.abort), 32'd1);
    check("drop_gv", 32'(bus.grant_valid), 32'd0);
    @(negedge clk);

    // Reset during a grant; pointer must restart at 0 (port 8 would win otherwise).
    set_prio(4, 3'd1);
    bus.request = 16'h0010;
    wait_grant();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_trans", 32'(bus.transfering), 32'd0);
    check("rst_mid_gv", 32'(bus.grant_valid), 32'd0);
    bus.request = '0;
    @(negedge clk);
    rst = 1'b1;
    set_prio(0, 3'd2); set_prio(8, 3'd2);
    bus.request = 16'h0101;
    wait_grant();
    check("post_reset_port", 32'(bus.grant_port), 32'd0);
    bus.eop[0] = 1'b1;
    bus.request = '0;
    @(negedge clk);
    bus.eop = '0;
    repeat (3) @(negedge clk);

    check("log_size", 32'(log_port.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < log_port.size()) check($sformatf("log_port_%0d", i), 32'(log_port[i]), 32'(exp_ports[i]));
    end
    if (log_len.size() >= 10) begin
      check("rr_len", 32'(log_len[0]), 32'd2);
      check("single_len", 32'(log_len[4]), 32'd5);
      check("prio_len", 32'(log_len[5]), 32'd3);
      check("watchdog_len", 32'(log_len[8]), 32'd8);
      check("drop_len", 32'(log_len[9]), 32'd3);
    end
    check("abort_count", 32'(abort_cnt), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
